mult16_seq_ctrl: RTL and testbench



---
 rtl/mult16_pkg.sv | 18 +
 rtl/mult16_seq_ctrl_array8.sv | 22 ++
 rtl/mult16_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mult16_seq_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mult16_pkg.sv
// Shared definitions for the sequential 16x16 multiplier.
//   OpW   : operand width (16)
//   HalfW : half-operand width fed to the 8x8 core (8)
//   StepW : width of the partial-product step counter (2)
//   state_e : controller FSM states
package mult16_pkg;

    localparam int unsigned OpW   = 16;
    localparam int unsigned HalfW = 8;
    localparam int unsigned StepW = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mult16_seq_ctrl_array8.sv
// array8: 8x8 unsigned array multiplier core, purely combinational.
// Ports:
//   a_i [7:0]  multiplicand
//   b_i [7:0]  multiplier
//   p_o [15:0] product a_i * b_i
module array8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);

    // One AND-row per multiplier bit, summed with its positional weight.
    always_comb begin
        p_o = '0;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) begin
                p_o = p_o + (16'(a_i) << i);
            end
        end
    end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// mult16_seq_ctrl: 16x16 unsigned multiplier that reuses a single 8x8 core over
// four cycles, with valid/ready handshakes on operand and result sides.
// Optional build macro MULT16_ZERO_BYPASS_EN: a zero operand at the accept edge
// skips the multiply sequence and goes straight to DONE with c = 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake (ready only in IDLE)
//   a, b            16-bit unsigned operands, latched on accept
//   out_valid/ready result handshake (valid only in DONE)
//   c               32-bit product register
//   busy            high in MUL or DONE
//   op_count        completed result handshakes, wraps modulo 2^CNT_W
module mult16_seq_ctrl
    import mult16_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OpW-1:0]     a,
    input  logic [OpW-1:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*OpW-1:0]   c,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    state_e               state_q, state_d;
    logic [StepW-1:0]     step_q, step_d;
    logic [OpW-1:0]       a_q, a_d;
    logic [OpW-1:0]       b_q, b_d;
    logic [2*OpW-1:0]     acc_q, acc_d;
    logic [2*OpW-1:0]     c_q, c_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [HalfW-1:0]     mul_a, mul_b;
    logic [2*HalfW-1:0]   pp;
    logic [2*OpW-1:0]     pp_ext, term;
    logic                 accept;

    assign accept = in_valid && (state_q == StIdle);

`ifdef MULT16_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (a == '0) || (b == '0);
`endif

    // step[0] picks the high half of a, step[1] the high half of b:
    // 0: aL*bL, 1: aH*bL, 2: aL*bH, 3: aH*bH.
    assign mul_a = step_q[0] ? a_q[OpW-1:HalfW] : a_q[HalfW-1:0];
    assign mul_b = step_q[1] ? b_q[OpW-1:HalfW] : b_q[HalfW-1:0];

    array8 u_core (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (pp)
    );

    assign pp_ext = {{(2*OpW-2*HalfW){1'b0}}, pp};

    always_comb begin
        term = pp_ext;
        unique case (step_q)
            2'd0:       term = pp_ext;
            2'd1, 2'd2: term = pp_ext << HalfW;
            default:    term = pp_ext << (2 * HalfW);
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef MULT16_ZERO_BYPASS_EN
                    state_d = zero_op ? StDone : StMul;
`else
                    state_d = StMul;
`endif
                end
            end
            StMul: begin
                if (step_q == 2'd3) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    assign c        = c_q;
    assign op_count = cnt_q;

    // Datapath next-state.
    always_comb begin
        step_d = step_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d    = a;
                    b_d    = b;
                    acc_d  = '0;
                    step_d = '0;
`ifdef MULT16_ZERO_BYPASS_EN
                    if (zero_op) begin
                        c_d = '0;
                    end
`endif
                end
            end
            StMul: begin
                step_d = step_q + 2'd1;
                // Last term goes straight into c; acc is not needed afterwards.
                if (step_q == 2'd3) begin
                    c_d = acc_q + term;
                end else begin
                    acc_d = acc_q + term;
                end
            end
            StDone: begin
                if (out_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
        end else begin
            step_q <= step_d;
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Self-checking bench for mult16_seq_ctrl. Two instances share all inputs:
// one with the default 16-bit counter, one with CNT_W=2 to exercise wrapping.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mult16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a, b;
    logic        out_ready;

    logic        in_ready, out_valid, busy;
    logic [31:0] c;
    logic [15:0] op_count;

    logic        in_ready2, out_valid2, busy2;
    logic [31:0] c2;
    logic [1:0]  op_count2;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    mult16_seq_ctrl #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy),
        .op_count  (op_count)
    );

    mult16_seq_ctrl #(.CNT_W(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .c         (c2),
        .busy      (busy2),
        .op_count  (op_count2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] va, input logic [15:0] vb);
`ifdef MULT16_ZERO_BYPASS_EN
        if (va == 16'h0 || vb == 16'h0) return 1;
`endif
        return 5;
    endfunction

    // One full operation with out_ready held high throughout.
    task automatic do_op(input logic [15:0] va, input logic [15:0] vb, input logic [31:0] vc);
        int cyc = 0;
        @(negedge clk);
        out_ready = 1'b1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = va;
        b = vb;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                in_valid = 1'b0;
                a = ~va;
                b = va ^ vb ^ 16'h5a5a;
                chk("in_ready_drop", 32'(in_ready), 32'd0);
                chk("busy_high", 32'(busy), 32'd1);
            end
            if (out_valid) break;
        end
        chk("latency", 32'(cyc), 32'(exp_lat(va, vb)));
        chk("product", c, vc);
        chk("product_cnt2", c2, vc);
        model_cnt++;
        @(negedge clk);
        chk("out_valid_clear", 32'(out_valid), 32'd0);
        chk("back_idle", 32'(in_ready), 32'd1);
        chk("c_holds", c, vc);
        chk("op_count", 32'(op_count), 32'(model_cnt));
        chk("op_count_w2", 32'(op_count2), 32'(model_cnt % 4));
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
        vecs[3] = '{16'h0000, 16'hABCD, 32'h0000_0000};
        vecs[4] = '{16'h0001, 16'h0001, 32'h0000_0001};
        vecs[5] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[6] = '{16'h00FF, 16'h00FF, 32'h0000_FE01};
        vecs[7] = '{16'hFF00, 16'hFF00, 32'hFE01_0000};
        vecs[8] = '{16'hABCD, 16'h0000, 32'h0000_0000};
        vecs[9] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_c", c, 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);

        // Reset during step2 aborts with no output.
        in_valid = 1'b1;
        a = 16'h00FF;
        b = 16'h0100;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_c", c, 32'd0);
        chk("abort_op_count", 32'(op_count), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_output", 32'(out_valid), 32'd0);

        // Table: includes 0x00FF*0x0100 right after the abort.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c);
        end

        // Backpressure: result held, extra operands ignored.
        begin
            int cyc = 0;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 16'h1234;
            b = 16'h5678;
            @(negedge clk);
            in_valid = 1'b0;
            while (!out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk("bp_valid", 32'(out_valid), 32'd1);
            in_valid = 1'b1;
            a = 16'hFFFF;
            b = 16'hFFFF;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_c", c, 32'h0626_0060);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            model_cnt++;
            @(negedge clk);
            chk("bp_release_valid", 32'(out_valid), 32'd0);
            chk("bp_release_idle", 32'(in_ready), 32'd1);
            chk("bp_op_count", 32'(op_count), 32'(model_cnt));
            chk("bp_c_kept", c, 32'h0626_0060);
        end
        do_op(16'h0003, 16'h0005, 32'h0000_000F);

        // Reset after activity clears the result register and counter.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst2_c", c, 32'd0);
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_op_count", 32'(op_count), 32'd0);
        chk("rst2_op_count_w2", 32'(op_count2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
